// File: rtl/brch_redirect_pkg.sv
// Shared definitions for the branch redirect block and the EX condition evaluator.
// Holds the state encoding, the default flush depth and the brch_instr field layout.
package brch_redirect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REDIR = 2'b01,
    FLUSH = 2'b10
  } state_e;

  localparam int FLUSH_DEPTH_DEF = 2;
  localparam int FCNT_W          = 3;

  // brch_instr layout: bit 2 flags a conditional branch, [1:0] is the condition code
  localparam int BRCH_BIT    = 2;
  localparam int BRCH_CC_MSB = 1;
  localparam int BRCH_CC_LSB = 0;

endpackage

// File: rtl/brch_redirect_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // count enabled events until the all-ones ceiling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/brch_redirect.sv
// Predict-not-taken redirect unit: turns a taken branch/jump resolved in EX into a
// registered fetch redirect followed by a fixed-length IF/ID flush window.
module brch_redirect
  import brch_redirect_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_is_brch,
  input  logic             ex_is_jmp,
  input  logic             BrchCnd,
  input  logic [WIDTH-1:0] ex_pc_inc,
  input  logic [WIDTH-1:0] ex_imm,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_DEPTH - 1);

  state_e              state_r, state_nx_s;
  logic [FCNT_W-1:0]   flush_cnt_r, flush_cnt_nx_s;
  logic                take_s, cap_s;
  logic [WIDTH-1:0]    target_s;

  assign take_s   = ex_valid & ((ex_is_brch & BrchCnd) | ex_is_jmp);
  assign target_s = ex_pc_inc + ex_imm;

  // next-state logic; stall freezes everything, EX is only looked at in IDLE
  always_comb begin
    state_nx_s     = state_r;
    flush_cnt_nx_s = flush_cnt_r;
    cap_s          = 1'b0;
    if (!stall) begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            state_nx_s = REDIR;
            cap_s      = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end
        REDIR: begin
          if (FLUSH_DEPTH == 1) begin
            state_nx_s     = IDLE;
            flush_cnt_nx_s = {FCNT_W{1'b0}};
          end else begin
            state_nx_s     = FLUSH;
            flush_cnt_nx_s = FLUSH_LOAD;
          end
        end
        FLUSH: begin
          // leave on the edge that takes the count to zero: FLUSH lasts DEPTH-1 cycles
          if (flush_cnt_r <= 3'd1) begin
            state_nx_s     = IDLE;
            flush_cnt_nx_s = {FCNT_W{1'b0}};
          end else begin
            flush_cnt_nx_s = flush_cnt_r - 3'd1;
          end
        end
        default: begin
          state_nx_s     = IDLE;
          flush_cnt_nx_s = {FCNT_W{1'b0}};
        end
      endcase
    end else begin
      cap_s = 1'b0;
    end
  end

  // state, target and Moore outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      flush_cnt_r <= {FCNT_W{1'b0}};
      redirect_pc <= {WIDTH{1'b0}};
      redirect    <= 1'b0;
      flush_if    <= 1'b0;
      flush_id    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      flush_cnt_r <= flush_cnt_nx_s;
      redirect_pc <= cap_s ? target_s : redirect_pc;
      redirect    <= (state_nx_s == REDIR);
      flush_if    <= (state_nx_s != IDLE);
      flush_id    <= (state_nx_s != IDLE);
      busy        <= (state_nx_s != IDLE);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cap_s),
    .cnt   (taken_cnt)
  );

endmodule

// File: tb/tb_brch_redirect.sv
// Directed bench for brch_redirect: a cycle model pushes expected outputs per step,
// and they are popped and checked after the following clock edge.
module tb_brch_redirect;

  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        rst_n, stall, ex_valid, ex_is_brch, ex_is_jmp, BrchCnd;
  logic [15:0] ex_pc_inc, ex_imm;
  logic        redirect, flush_if, flush_id, busy;
  logic [15:0] redirect_pc, taken_cnt;
  logic        redirect4, flush_if4, flush_id4, busy4;
  logic [15:0] redirect_pc4;
  logic [3:0]  taken_cnt4;

  typedef struct {
    logic        redir;
    logic        fl;
    logic [15:0] pc;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // independent model: remaining flush cycles, first-cycle flag, target, count
  int          m_left  = 0;
  bit          m_first = 1'b0;
  logic [15:0] m_pc    = 16'h0000;
  int          m_cnt   = 0;

  brch_redirect #(.WIDTH(16), .FLUSH_DEPTH(FD), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_is_brch(ex_is_brch), .ex_is_jmp(ex_is_jmp), .BrchCnd(BrchCnd),
    .ex_pc_inc(ex_pc_inc), .ex_imm(ex_imm), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .busy(busy), .taken_cnt(taken_cnt));

  brch_redirect #(.WIDTH(16), .FLUSH_DEPTH(FD), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_is_brch(ex_is_brch), .ex_is_jmp(ex_is_jmp), .BrchCnd(BrchCnd),
    .ex_pc_inc(ex_pc_inc), .ex_imm(ex_imm), .redirect(redirect4),
    .redirect_pc(redirect_pc4), .flush_if(flush_if4), .flush_id(flush_id4),
    .busy(busy4), .taken_cnt(taken_cnt4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit st, input bit v, input bit br, input bit jp,
                     input bit cnd, input logic [15:0] pc, input logic [15:0] imm);
    exp_t e;
    bit   tk;
    stall = st; ex_valid = v; ex_is_brch = br; ex_is_jmp = jp; BrchCnd = cnd;
    ex_pc_inc = pc; ex_imm = imm;
    tk = v && ((br && cnd) || jp);
    if (!st) begin
      if (m_left > 0) begin
        m_left--;
        m_first = 1'b0;
      end else if (tk) begin
        m_left  = FD;
        m_first = 1'b1;
        m_pc    = pc + imm;
        m_cnt++;
      end
    end
    e.redir = m_first;
    e.fl    = (m_left > 0);
    e.pc    = m_pc;
    e.cnt   = 16'(m_cnt);
    e.cnt4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
    chk("redirect_pc", {16'd0, redirect_pc}, {16'd0, e.pc});
    chk("flush_if", {31'd0, flush_if}, {31'd0, e.fl});
    chk("flush_id", {31'd0, flush_id}, {31'd0, e.fl});
    chk("busy", {31'd0, busy}, {31'd0, e.fl});
    chk("taken_cnt", {16'd0, taken_cnt}, {16'd0, e.cnt});
    chk("redirect4", {31'd0, redirect4}, {31'd0, e.redir});
    chk("busy4", {31'd0, busy4 & flush_if4 & flush_id4}, {31'd0, e.fl});
    chk("redirect_pc4", {16'd0, redirect_pc4}, {16'd0, e.pc});
    chk("taken_cnt4", {28'd0, taken_cnt4}, {28'd0, e.cnt4});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {28'd0, redirect, flush_if, flush_id, busy}, 32'd0);
    chk({tag, "_pc"}, {16'd0, redirect_pc}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, taken_cnt}, 32'd0);
    chk({tag, "_cnt4"}, {28'd0, taken_cnt4}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_is_brch = 1'b0;
    ex_is_jmp = 1'b0; BrchCnd = 1'b0; ex_pc_inc = 16'h0000; ex_imm = 16'h0000;
    #3;
    chk_all_zero("reset");
    #8 rst_n = 1'b1;

    // taken branch 0x40 + (-8)
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'hFFF8);
    chk("taken_pc_const", {16'd0, redirect_pc}, 32'h0000_0038);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("taken_busy_drop", {31'd0, busy}, 32'd0);

    // not-taken branch, invalid jump, both-high treated as jump
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2000, 16'h0020);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3000, 16'h0030);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0006);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // wrap-around jump, then a shadow taken branch during FLUSH
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0004);
    chk("wrap_pc_const", {16'd0, redirect_pc}, 32'h0000_0002);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5000, 16'h0100);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h6000, 16'h0100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // stall three cycles in REDIR, wrong-path take presented meanwhile
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0020);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0900, 16'h0002);
    chk("stall_redir_held", {31'd0, redirect}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0900, 16'h0002);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // saturation of the 4-bit counter instance
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'(i * 4), 16'h0010);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    chk("sat_cnt4", {28'd0, taken_cnt4}, 32'h0000_000F);

    // reset asserted in the middle of FLUSH
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0400, 16'h0040);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("pre_reset_flush", {31'd0, flush_if}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    m_left = 0; m_first = 1'b0; m_pc = 16'h0000; m_cnt = 0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk_all_zero("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
